// File: rtl/ep0_pkg.sv
// ep0_pkg: token/handshake/data PIDs, FSM state encoding and SETUP byte offsets
// shared by the EP0 control sequencer.
package ep0_pkg;
  localparam logic [1:0] TOK_SETUP = 2'd0, TOK_IN = 2'd1, TOK_OUT = 2'd2;
  localparam logic [1:0] HS_ACK = 2'd0, HS_NAK = 2'd1, HS_STALL = 2'd2;
  localparam logic DATA0 = 1'b0, DATA1 = 1'b1;
  localparam int OFF_BM_REQUEST_TYPE = 0, OFF_B_REQUEST = 1, OFF_W_VALUE = 2, OFF_W_INDEX = 4, OFF_W_LENGTH = 6;
  typedef enum logic [2:0] {IDLE, SETUP_RX, DATA_IN, WAIT_HS, STATUS_IN, STATUS_OUT} state_t;
endpackage

// File: rtl/ep0_control_sequencer_if.sv
// ep0_control_sequencer_if: received byte stream plus the SETUP capture results.
interface ep0_control_sequencer_if;
  logic [7:0] data;
  logic valid;
  logic pkt_end;
  logic pkt_ok;
  logic clear;
  logic [7:0][7:0] setup;
  logic [3:0] count;
  modport master (output data, valid, pkt_end, pkt_ok, clear, input setup, count);
  modport slave (input data, valid, clear, output setup, count);
endinterface

// File: rtl/ep0_setup_capture.sv
// ep0_setup_capture: keeps the first eight bytes of a received packet and a
// 4-bit saturating byte count, cleared by any token.
module ep0_setup_capture (
  input logic clk,
  input logic reset_n,
  ep0_control_sequencer_if.slave cap
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cap.setup <= '0;
      cap.count <= '0;
    end else if (cap.clear) cap.count <= '0;
    else if (cap.valid) begin
      if (!cap.count[3]) cap.setup[cap.count[2:0]] <= cap.data;
      if (cap.count != 4'hf) cap.count <= cap.count + 4'd1;
    end
endmodule

// File: rtl/ep0_control_sequencer.sv
// ep0_control_sequencer: USB endpoint-0 control transfer sequencer (SETUP, IN data, status).
// Define EP0_SEQ_TIMEOUT_EN to add an internal handshake-wait timeout of TIMEOUT_CYCLES.
module ep0_control_sequencer import ep0_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 640
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tokenValid,
  input  logic [1:0]  tokenPid,
  input  logic [7:0]  rxByte,
  input  logic        rxByteValid,
  input  logic        rxPacketEnd,
  input  logic        rxPacketOk,
  input  logic        hostAck,
  input  logic        txnTimeout,
  output logic        clearRequest,
  output logic        requestValid,
  output logic        bmRequestTypeDPTD,
  output logic [1:0]  bmRequestTypeType,
  output logic [4:0]  bmRequestTypeRecipient,
  output logic [7:0]  bRequest,
  output logic [15:0] wValue,
  output logic [15:0] wIndex,
  output logic [15:0] wLength,
  input  logic [7:0]  outByte,
  input  logic        outByteValid,
  input  logic        outByteLast,
  output logic        outByteAck,
  output logic        commitWrite,
  output logic        resetWrite,
  output logic        sendHandshake,
  output logic [1:0]  handshakePid,
  output logic        txStart,
  output logic        txDataPid,
  output logic [7:0]  txByte,
  output logic        txByteValid,
  input  logic        txByteReady,
  output logic        txLast,
  output logic        statusDone
);
  state_t state, state_d;
  logic busy, busy_d, toggle, toggle_d, req, req_d, zlp, zlp_d, latch;
  logic clr_d, hs_d, start_d, dpid_d, commit_d, rewind_d, done_d;
  logic [1:0] hs_pid_d;
  logic setup_tok, in_tok, out_tok, sending, timeout, pkt_good;
  logic [15:0] setup_wlength;
  ep0_control_sequencer_if cap ();
  assign setup_tok = tokenValid && tokenPid == TOK_SETUP;
  assign in_tok = tokenValid && tokenPid == TOK_IN;
  assign out_tok = tokenValid && tokenPid == TOK_OUT;
  assign cap.data = rxByte;
  assign cap.valid = rxByteValid && (state == SETUP_RX || state == STATUS_OUT);
  assign cap.clear = tokenValid;
  assign cap.pkt_end = rxPacketEnd;
  assign cap.pkt_ok = rxPacketOk;
  assign pkt_good = cap.pkt_end && cap.pkt_ok;
  assign setup_wlength = {cap.setup[OFF_W_LENGTH+1], cap.setup[OFF_W_LENGTH]};
  ep0_setup_capture u_capture (.clk(clk), .reset_n(reset_n), .cap(cap));
  assign sending = busy && state == DATA_IN;
  assign txByte = sending ? outByte : '0;
  assign txByteValid = sending && outByteValid;
  assign txLast = zlp || (sending && outByteLast);
  assign outByteAck = txByteValid && txByteReady;
  assign requestValid = req && !setup_tok;
`ifdef EP0_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;
  logic waiting, int_timeout;
  assign waiting = state == WAIT_HS || (state == STATUS_IN && busy);
  assign int_timeout = wait_cnt >= TW'(TIMEOUT_CYCLES);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) wait_cnt <= '0;
    else if (!waiting || zlp) wait_cnt <= '0;
    else if (!int_timeout) wait_cnt <= wait_cnt + TW'(1);
  assign timeout = txnTimeout || int_timeout;
`else
  if (TIMEOUT_CYCLES >= 0) begin : g_ext_timeout
    assign timeout = txnTimeout;
  end
`endif
  always_comb begin
    state_d = state; busy_d = busy; toggle_d = toggle; req_d = req; zlp_d = 1'b0; latch = 1'b0;
    clr_d = 1'b0; hs_d = 1'b0; hs_pid_d = HS_ACK; start_d = 1'b0; dpid_d = DATA0;
    commit_d = 1'b0; rewind_d = 1'b0; done_d = 1'b0;
    if (setup_tok) begin
      state_d = SETUP_RX; busy_d = 1'b0; req_d = 1'b0;
    end else case (state)
      SETUP_RX: if (cap.pkt_end) begin
        if (pkt_good && cap.count == 4'd8) begin
          latch = 1'b1; clr_d = 1'b1; hs_d = 1'b1; toggle_d = 1'b1; req_d = 1'b1;
          state_d = cap.setup[OFF_BM_REQUEST_TYPE][7] && setup_wlength != '0 ? DATA_IN : STATUS_IN;
        end else state_d = IDLE;
      end
      DATA_IN: if (busy) begin
        if (outByteAck && outByteLast) begin busy_d = 1'b0; state_d = WAIT_HS; end
      end else if (in_tok) begin busy_d = 1'b1; start_d = 1'b1; dpid_d = toggle; end
      else if (out_tok) state_d = STATUS_OUT;
      WAIT_HS: if (hostAck) begin commit_d = 1'b1; toggle_d = ~toggle; state_d = DATA_IN; end
      else if (timeout) begin rewind_d = 1'b1; state_d = DATA_IN; end
      STATUS_IN: if (in_tok) begin busy_d = 1'b1; start_d = 1'b1; zlp_d = 1'b1; dpid_d = DATA1; end
      else if (out_tok) begin hs_d = 1'b1; hs_pid_d = HS_STALL; state_d = IDLE; end
      else if (busy && hostAck) begin done_d = 1'b1; state_d = IDLE; end
      STATUS_OUT: if (in_tok) begin hs_d = 1'b1; hs_pid_d = HS_STALL; state_d = IDLE; end
      else if (pkt_good && cap.count == 4'd0) begin hs_d = 1'b1; done_d = 1'b1; state_d = IDLE; end
      default: if (in_tok || out_tok) begin hs_d = 1'b1; hs_pid_d = HS_STALL; end
    endcase
    if (state_d == IDLE) begin req_d = 1'b0; busy_d = 1'b0; end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE; busy <= 1'b0; toggle <= 1'b0; req <= 1'b0; zlp <= 1'b0;
      clearRequest <= 1'b0; sendHandshake <= 1'b0; handshakePid <= HS_ACK;
      txStart <= 1'b0; txDataPid <= DATA0; commitWrite <= 1'b0; resetWrite <= 1'b0; statusDone <= 1'b0;
      bmRequestTypeDPTD <= 1'b0; bmRequestTypeType <= '0; bmRequestTypeRecipient <= '0;
      bRequest <= '0; wValue <= '0; wIndex <= '0; wLength <= '0;
    end else begin
      state <= state_d; busy <= busy_d; toggle <= toggle_d; req <= req_d; zlp <= zlp_d;
      clearRequest <= clr_d; sendHandshake <= hs_d; handshakePid <= hs_pid_d;
      txStart <= start_d; txDataPid <= dpid_d; commitWrite <= commit_d; resetWrite <= rewind_d; statusDone <= done_d;
      if (latch) begin
        {bmRequestTypeDPTD, bmRequestTypeType, bmRequestTypeRecipient} <= cap.setup[OFF_BM_REQUEST_TYPE];
        bRequest <= cap.setup[OFF_B_REQUEST];
        wValue <= {cap.setup[OFF_W_VALUE+1], cap.setup[OFF_W_VALUE]};
        wIndex <= {cap.setup[OFF_W_INDEX+1], cap.setup[OFF_W_INDEX]};
        wLength <= setup_wlength;
      end
    end
endmodule

// File: doc/ep0_control_sequencer.md
EP0_CONTROL_SEQUENCER -- requirements
Module: ep0_control_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 640: handshake-wait limit in clk cycles, used only with EP0_SEQ_TIMEOUT_EN.
REQ-002 SHALL have ports, in this order:
- clk  in  1  sole clock; all logic on its rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- tokenValid  in  1  one-cycle pulse: token for this device's EP0 received.
- tokenPid  in  2  token type: 0 SETUP, 1 IN, 2 OUT.
- rxByte  in  8  received data-packet byte.
- rxByteValid  in  1  rxByte qualifier.
- rxPacketEnd  in  1  one-cycle pulse: end of received data packet.
- rxPacketOk  in  1  CRC/PID good; valid with rxPacketEnd.
- hostAck  in  1  pulse: host ACK after device DATA packet.
- txnTimeout  in  1  pulse: host handshake never arrived.
- clearRequest  out  1  pulse: new SETUP accepted.
- requestValid  out  1  control transfer in progress; request fields valid.
- bmRequestTypeDPTD  out  1  direction bit.
- bmRequestTypeType  out  2  type field.
- bmRequestTypeRecipient  out  5  recipient field.
- bRequest  out  8.
- wValue, wIndex, wLength  out  16 each  little-endian from SETUP bytes 2-7.
- outByte  in  8;  outByteValid  in  1;  outByteLast  in  1  register-block source stream.
- outByteAck  out  1  consumes outByte.
- commitWrite  out  1  pulse: IN packet acknowledged.
- resetWrite  out  1  pulse: IN packet lost; rewind.
- sendHandshake  out  1;  handshakePid  out  2 (0 ACK, 1 NAK, 2 STALL).
- txStart  out  1  pulse: begin device DATA packet;  txDataPid  out  1 (0 DATA0, 1 DATA1).
- txByte  out  8;  txByteValid  out  1;  txByteReady  in  1;  txLast  out  1.
- statusDone  out  1  pulse: status stage completed.

Function
REQ-003 SHALL implement states IDLE, SETUP_RX, DATA_IN, WAIT_HS, STATUS_IN, STATUS_OUT.
REQ-004 SETUP token in any state SHALL enter SETUP_RX, zero the byte count and deassert requestValid that cycle.
REQ-005 In SETUP_RX, byte k (k<8) SHALL be stored at offset k; bytes beyond 8 SHALL be ignored but counted (4-bit saturating).
REQ-006 rxPacketEnd with rxPacketOk and count==8 SHALL, next cycle, latch fields, pulse clearRequest and sendHandshake(ACK), set toggle=1, and assert requestValid; otherwise return to IDLE silently.
REQ-007 After SETUP: DPTD=1 and wLength!=0 -> DATA_IN; otherwise -> STATUS_IN.
REQ-008 DATA_IN on IN token SHALL pulse txStart with txDataPid=toggle, then forward outByte to txByte; txByteValid=outByteValid.
REQ-009 outByteAck SHALL equal txByteValid & txByteReady (combinational); txLast SHALL mirror outByteLast; the txLast beat SHALL end the packet and enter WAIT_HS.
REQ-010 WAIT_HS: hostAck -> commitWrite pulse, toggle inverted, back to DATA_IN; txnTimeout -> resetWrite pulse, toggle kept, back to DATA_IN.
REQ-011 OUT token in DATA_IN SHALL enter STATUS_OUT; a zero-length rxPacketOk packet SHALL be ACKed, pulse statusDone, go IDLE.
REQ-012 STATUS_IN on IN token SHALL send zero-length DATA1 (txStart+txLast same cycle, no bytes); hostAck -> statusDone, IDLE; txnTimeout -> stay.
REQ-013 IN/OUT tokens in IDLE, or of the wrong direction in a stage, SHALL produce sendHandshake(STALL) and go IDLE.
REQ-014 hostAck and txnTimeout in the same cycle SHALL be treated as hostAck.

Reset
REQ-015 reset_n low SHALL force IDLE, toggle=0, counters 0, all outputs and latched fields 0, immediately; mid-transfer reset SHALL discard the transfer with no commitWrite/resetWrite.

Configuration
REQ-016 With EP0_SEQ_TIMEOUT_EN defined, an internal counter SHALL start on WAIT_HS/STATUS_IN-data entry and raise an internal timeout at TIMEOUT_CYCLES, ORed with txnTimeout; without it, txnTimeout alone SHALL be used and no counter synthesized.

Structure
REQ-017 Package ep0_pkg SHALL hold token/handshake/data PID constants, state encoding and SETUP byte offsets.
REQ-018 Sub-module ep0_setup_capture SHALL hold the 8-byte capture and count.

Verification
REQ-019 SETUP 80 06 00 01 00 00 12 00, OK -> ACK, clearRequest, wValue=0x0100, wLength=0x0012, DATA_IN.
REQ-020 IN, 8 bytes, hostAck -> DATA1 packet, 8 outByteAck, commitWrite, next IN uses DATA0.
REQ-021 IN then txnTimeout -> resetWrite, retry keeps DATA1.
REQ-022 SETUP 00 05 07 00 00 00 00 00 -> STATUS_IN; IN -> ZLP DATA1; hostAck -> statusDone, IDLE.
REQ-023 SETUP with 7 bytes or rxPacketOk=0 -> no ACK, IDLE; SETUP mid-DATA_IN -> restart.
REQ-024 reset_n low during WAIT_HS -> all outputs 0 without waiting for clk.
